// File: rtl/lsu_mem_bridge_pkg.sv
// lsu_mem_bridge_pkg: shared types and constants for the LSU-to-RAM bridge
package lsu_mem_bridge_pkg;
  localparam int MBUS = 32;
  localparam int ADDR_W = 10;
  localparam int TIMEOUT = 15;
  localparam int CNT_W = 8;
  typedef enum logic {IDLE, REQ} mem_state_t;
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [MBUS-1:0]   wdata;
  } mem_req_t;
  typedef logic [1:0] err_code_t;
  localparam err_code_t ERR_CONFLICT = 2'd0;
  localparam err_code_t ERR_MISALIGN = 2'd1;
  localparam err_code_t ERR_RANGE    = 2'd2;
  localparam err_code_t ERR_TIMEOUT  = 2'd3;
endpackage

// File: rtl/lsu_mem_bridge_if.sv
// lsu_mem_bridge_if: processor-side and RAM-side signals of the bridge
interface lsu_mem_bridge_if;
  import lsu_mem_bridge_pkg::*;
  logic              MRE;
  logic              MWE;
  logic [MBUS-1:0]   addressData;
  logic [MBUS-1:0]   storeData;
  logic [MBUS-1:0]   loadedData;
  logic              load_valid;
  logic              stall;
  logic              mem_err;
  err_code_t         err_code;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [MBUS-1:0]   mem_wdata;
  logic [MBUS-1:0]   mem_rdata;
  logic              mem_ack;
  modport master (
    output MRE, MWE, addressData, storeData, mem_rdata, mem_ack,
    input  loadedData, load_valid, stall, mem_err, err_code, mem_req, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  MRE, MWE, addressData, storeData, mem_rdata, mem_ack,
    output loadedData, load_valid, stall, mem_err, err_code, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_bridge_mem_req_check.sv
// lsu_mem_bridge_mem_req_check: combinational legality check of a processor memory request
module lsu_mem_bridge_mem_req_check
  import lsu_mem_bridge_pkg::*;
(
  input  logic              mre_i,
  input  logic              mwe_i,
  input  logic [MBUS-1:0]   addr_i,
  output logic              legal_o,
  output logic              err_o,
  output err_code_t         code_o,
  output logic [ADDR_W-1:0] word_o
);
  logic req, conflict, misalign, oor, bad;
  // classify the request; conflict outranks misalignment, which outranks range
  always_comb begin
    req      = mre_i | mwe_i;
    conflict = mre_i & mwe_i;
    misalign = |addr_i[1:0];
    oor      = |addr_i[MBUS-1:ADDR_W+2];
    bad      = conflict | misalign | oor;
    legal_o  = req & ~bad;
    err_o    = req & bad;
    code_o   = conflict ? ERR_CONFLICT : misalign ? ERR_MISALIGN : ERR_RANGE;
    word_o   = addr_i[ADDR_W+1:2];
  end
endmodule

// File: rtl/lsu_mem_bridge.sv
// lsu_mem_bridge: turns processor load/store strobes into a req/ack RAM access with stall
module lsu_mem_bridge
  import lsu_mem_bridge_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  lsu_mem_bridge_if.slave  bus
);
  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  mem_req_t          req_q, req_d;
  logic [MBUS-1:0]   ld_q, ld_d;
  logic              lv_q, lv_d, err_q, err_d;
  err_code_t         code_q, code_d, chk_code;
  logic              legal, chk_err;
  logic [ADDR_W-1:0] word;

  lsu_mem_bridge_mem_req_check u_chk (
    .mre_i   (bus.MRE),
    .mwe_i   (bus.MWE),
    .addr_i  (bus.addressData),
    .legal_o (legal),
    .err_o   (chk_err),
    .code_o  (chk_code),
    .word_o  (word)
  );

  assign cnt_inc        = cnt_q + 1'b1;
  assign bus.mem_req    = state_q == REQ;
  assign bus.mem_we     = req_q.we;
  assign bus.mem_addr   = req_q.addr;
  assign bus.mem_wdata  = req_q.wdata;
  assign bus.loadedData = ld_q;
  assign bus.load_valid = lv_q;
  assign bus.mem_err    = err_q;
  assign bus.err_code   = code_q;
  assign bus.stall      = (state_q == REQ) | ((state_q == IDLE) & legal);

  // next state: accept or reject in IDLE, wait for ack or time out in REQ
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    ld_d    = ld_q;
    lv_d    = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    if (state_q == IDLE) begin
      if (legal) begin
        state_d = REQ;
        cnt_d   = '0;
        req_d   = '{we: bus.MWE, addr: word, wdata: bus.storeData};
      end else if (chk_err) begin
        err_d  = 1'b1;
        code_d = chk_code;
        lv_d   = bus.MRE;
        ld_d   = bus.MRE ? '0 : ld_q;
      end
    end else if (bus.mem_ack) begin
      state_d = IDLE;
      lv_d    = ~req_q.we;
      ld_d    = req_q.we ? ld_q : bus.mem_rdata;
    end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
      state_d = IDLE;
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
      lv_d    = ~req_q.we;
      ld_d    = req_q.we ? ld_q : '0;
    end else begin
      cnt_d = cnt_inc;
    end
  end

  // state, counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      ld_q    <= '0;
      lv_q    <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_CONFLICT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      ld_q    <= ld_d;
      lv_q    <= lv_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end
endmodule

// File: doc/lsu_mem_bridge.md
Name: lsu_mem_bridge

Overview:
- Sits directly downstream of Processor's memory port.
- Consumes MRE/MWE/addressData/storeData and returns loadedData.
- Converts single-cycle processor load/store strobes into a req/ack handshake to a word-addressed data RAM, and stalls the core while the access is outstanding.
- Detects misaligned, out-of-range and conflicting requests, plus memory timeouts, and reports them without touching memory.

Parameters:
- mbus, 32: data and byte-address width; matches Processor mbus.
- ADDR_W, 10: RAM word-address width; legal byte range is 0 .. 4*2^ADDR_W-1.
- TIMEOUT, 15: maximum cycles in REQ without mem_ack before abort (1..255).

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- MRE  in  1  load request from Processor
- MWE  in  1  store request from Processor
- addressData  in  mbus  byte address from Processor
- storeData  in  mbus  store data from Processor
- loadedData  out  mbus  load result to Processor
- load_valid  out  1  one-cycle pulse: loadedData updated
- stall  out  1  core must hold its memory instruction
- mem_err  out  1  one-cycle pulse: request rejected or timed out
- mem_req  out  1  RAM request
- mem_we  out  1  RAM write enable, qualified by mem_req
- mem_addr  out  ADDR_W  RAM word address (addressData[ADDR_W+1:2])
- mem_wdata  out  mbus  RAM write data
- mem_rdata  in  mbus  RAM read data, valid with mem_ack
- mem_ack  in  1  RAM completion

Behaviour:
- Reset values: state IDLE, wait counter 0, and every output 0: loadedData, load_valid, stall, mem_err, mem_req, mem_we, mem_addr, mem_wdata.
- States: IDLE, REQ.
- IDLE, request present (MRE|MWE):
  - Checked combinationally in the same cycle.
  - Error if MRE&MWE, or addressData[1:0]!=0, or addressData[mbus-1:ADDR_W+2]!=0.
  - Error case: stay IDLE; mem_err=1 next cycle. If MRE was set, also pulse load_valid next cycle with loadedData=0. No mem_req is issued.
  - Legal case: latch mem_addr, mem_wdata=storeData, mem_we=MWE; go to REQ; clear counter.
- stall = (state==REQ) | (state==IDLE & legal request).
  - This is a combinational path from MRE/MWE/addressData, so stall is high in the acceptance cycle.
- REQ:
  - mem_req=1; mem_addr, mem_we and mem_wdata are held stable.
  - Processor inputs are ignored.
  - mem_ack sampled 1 → go to IDLE and drop mem_req at that edge. For a read: loadedData<=mem_rdata and load_valid=1 for the following cycle. For a write: no load_valid.
  - mem_ack 0 → counter+1. When the counter reaches TIMEOUT: go to IDLE, drop mem_req, pulse mem_err. For a read, also set loadedData=0 and pulse load_valid.
- Latency, zero-wait RAM:
  - Request seen at cycle N; mem_req high in N+1; ack in N+1.
  - load_valid and data in N+2; stall high in N and N+1, low in N+2.
  - Each extra RAM wait cycle adds 1.
- Back-to-back: the cycle that carries load_valid is IDLE, so a new request is accepted in that cycle.
- mem_ack while IDLE is ignored.
- loadedData holds its last value except on read completion or read error.
- Reset mid-REQ: next edge goes to IDLE, mem_req=0, no load_valid or mem_err; a late ack is ignored.
- mem_err and load_valid are never high for more than one consecutive cycle per request.

Decomposition:
- Add to ProcessorStructs.sv:
  - typedef enum mem_state_t {IDLE, REQ}
  - packed struct mem_req_t {we, addr[ADDR_W-1:0], wdata[mbus-1:0]}
  - localparam for the error-code encoding (CONFLICT, MISALIGN, RANGE, TIMEOUT), exposed for debug.
- One sub-module, mem_req_check: combinational legality check producing legal, err and word address. The top module owns the FSM, counter and output registers.

Test Plan:
1. Load, zero-wait: MRE=1, addressData=0x8; RAM acks next cycle with 0x3F → mem_addr=2, mem_we=0, stall high 2 cycles, load_valid=1 with loadedData=0x3F at N+2.
2. Store, 3-wait: MWE=1, addressData=0xC, storeData=0x9; ack after 3 cycles → mem_addr=3, mem_we=1, mem_wdata=9, stall high 5 cycles, no load_valid, mem_err=0.
3. Errors: MRE with addressData=0x6 → mem_err and load_valid pulse with loadedData=0, no mem_req. Repeat with 0x1000 (ADDR_W=10) and with MRE&MWE=1 → same response.
4. Timeout: MRE, addr 0x4, ack never asserted → mem_req high exactly TIMEOUT=15 cycles, then mem_err=1, load_valid=1, loadedData=0, stall low.
5. Back-to-back: load 0x8 (data 0x3F), then store to 0x8 presented in the load_valid cycle → store accepted that cycle; mem_req low for exactly one cycle between the two requests.
6. Reset mid-REQ: rst=1 on the 2nd wait cycle, ack the cycle after → all outputs 0, ack ignored, next MRE starts a fresh access normally.
